// File: rtl/sm_boot_loader_pkg.sv
// Shared constants and state encoding for the boot loader.
// The frame start byte and FSM states live here so the top and any sub-blocks agree.
package sm_boot_loader_pkg;

    localparam logic [7:0] START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

    // States in which a stalled byte stream is treated as a broken frame.
    function automatic logic in_frame(state_t s);
        return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/sm_boot_loader_timer.sv
// Idle-cycle counter: counts cycles while enabled and not cleared, and flags
// expiry on the cycle whose edge would be the TIMEOUT-th idle edge.
module sm_boot_loader_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count;

    // Saturates at LIMIT so a long stall cannot wrap back below the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count < LIMIT) begin
            count <= count + ONE;
        end
    end

    assign expired = enable && (count >= LIMIT);

endmodule

// File: rtl/sm_boot_loader.sv
// Boot loader: parses a framed image from a byte stream, writes words to
// instruction memory and releases the CPU from reset after a valid checksum.
module sm_boot_loader
    import sm_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    input  logic                  reload,
    output logic [ADDR_WIDTH-1:0] imWAddr,
    output logic [31:0]           imWData,
    output logic                  imWe,
    output logic                  cpuRst_n,
    output logic                  loadDone,
    output logic                  loadErr
);

    localparam logic [16:0]         CAPACITY = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WORD_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state, state_next;
    logic [15:0]           word_count;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [7:0]            csum;
    logic                  accept;
    logic                  err_set;
    logic                  expired;
    logic                  timer_clear;
    logic                  last_word;
    logic [15:0]           count_full;

    assign rxReady    = (state != ST_DONE);
    assign accept     = rxValid && rxReady;
    assign cpuRst_n   = (state == ST_DONE);
    assign loadDone   = (state == ST_DONE);
    assign count_full = {rxData, word_count[7:0]};
    assign last_word  = (17'(word_idx) + 17'd1) == {1'b0, word_count};

    // Timer restarts on every accepted byte and on every state change.
    assign timer_clear = accept || (state_next != state);

    sm_boot_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (in_frame(state)),
        .clear   (timer_clear),
        .expired (expired)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        state_next = state;
        err_set    = 1'b0;
        unique case (state)
            ST_IDLE:   if (accept && rxData == START_BYTE) state_next = ST_CNT_LO;
            ST_CNT_LO: if (accept) state_next = ST_CNT_HI;
            ST_CNT_HI: begin
                if (accept) begin
                    if ({1'b0, count_full} > CAPACITY) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (count_full == 16'd0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA:   if (accept && byte_idx == 2'd3 && last_word) state_next = ST_CSUM;
            ST_CSUM: begin
                if (accept) begin
                    if (rxData == csum) begin
                        state_next = ST_DONE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DONE:   if (reload) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // An accepted byte takes priority over a timeout expiring on the same edge.
        if (in_frame(state) && !accept && expired) begin
            err_set    = 1'b1;
            state_next = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word_count <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            csum       <= '0;
            loadErr    <= 1'b0;
            imWe       <= 1'b0;
            imWAddr    <= '0;
            imWData    <= '0;
        end else begin
            state <= state_next;
            imWe  <= 1'b0;
            if (err_set) loadErr <= 1'b1;
            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        if (rxData == START_BYTE) begin
                            loadErr  <= 1'b0;
                            csum     <= '0;
                            word_idx <= '0;
                            byte_idx <= '0;
                        end
                    end
                    ST_CNT_LO: word_count[7:0]  <= rxData;
                    ST_CNT_HI: word_count[15:8] <= rxData;
                    ST_DATA: begin
                        csum     <= csum ^ rxData;
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word_buf[7:0]   <= rxData;
                            2'd1: word_buf[15:8]  <= rxData;
                            2'd2: word_buf[23:16] <= rxData;
                            2'd3: begin
                                imWe     <= 1'b1;
                                imWData  <= {rxData, word_buf};
                                imWAddr  <= word_idx[ADDR_WIDTH-1:0];
                                word_idx <= word_idx + WORD_ONE;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm_boot_loader.sv
// Self-checking bench for sm_boot_loader: frames are built from random words,
// and the expected writes, checksum and outcome come from a simple frame model.
module tb_sm_boot_loader;

    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rxData = 8'h00;
    logic          rxValid = 1'b0;
    logic          reload = 1'b0;
    logic          rxReady;
    logic [AW-1:0] imWAddr;
    logic [31:0]   imWData;
    logic          imWe;
    logic          cpuRst_n;
    logic          loadDone;
    logic          loadErr;

    sm_boot_loader #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .rxReady  (rxReady),
        .reload   (reload),
        .imWAddr  (imWAddr),
        .imWData  (imWData),
        .imWe     (imWe),
        .cpuRst_n (cpuRst_n),
        .loadDone (loadDone),
        .loadErr  (loadErr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  byte_q[$];
    logic [31:0] word_q[$];
    logic [31:0] wr_data_q[$];
    logic [AW-1:0] wr_addr_q[$];
    int          wr_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imWe === 1'b1) begin
            wr_addr_q.push_back(imWAddr);
            wr_data_q.push_back(imWData);
            wr_cyc_q.push_back(cyc);
        end
    end

    // Frame model: start byte, little-endian count, data bytes LSB first, XOR of data bytes.
    task automatic build_frame(input bit bad_csum);
        logic [7:0]  sum;
        logic [31:0] w;
        int          n;
        n   = word_q.size();
        sum = 8'h00;
        byte_q = {};
        byte_q.push_back(8'hA5);
        byte_q.push_back(8'(n % 256));
        byte_q.push_back(8'(n / 256));
        foreach (word_q[i]) begin
            w = word_q[i];
            for (int k = 0; k < 4; k++) begin
                byte_q.push_back(8'((w >> (8 * k)) & 32'hFF));
                sum = sum ^ 8'((w >> (8 * k)) & 32'hFF);
            end
        end
        byte_q.push_back(bad_csum ? (sum ^ 8'h01) : sum);
    endtask

    task automatic clear_writes();
        wr_addr_q = {};
        wr_data_q = {};
        wr_cyc_q  = {};
    endtask

    // Presents a byte at the falling edge; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        n_checks++;
        if (rxReady !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: rxReady=%b required 1", rxReady);
        end
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic stall(input int g);
        drop();
        repeat (g) @(posedge clk);
    endtask

    task automatic send_range(input int first, input int max_gap);
        for (int i = first; i < byte_q.size(); i++) begin
            if (max_gap > 0 && i > first) begin
                int g;
                g = $urandom_range(0, max_gap);
                if (g > 0) stall(g);
            end
            send_byte(byte_q[i]);
        end
    endtask

    task automatic go_idle();
        if (loadDone === 1'b1) begin
            @(negedge clk);
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
        end
    endtask

    task automatic check_writes(input string name);
        n_checks++;
        if (wr_addr_q.size() != word_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: writes=%0d required %0d", name, wr_addr_q.size(), word_q.size());
        end else begin
            foreach (word_q[i]) begin
                n_checks++;
                if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== word_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_word%0d: addr=%h data=%h required addr=%h data=%h",
                             name, i, wr_addr_q[i], wr_data_q[i], AW'(i), word_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr, imWe, rxReady} !== 5'b00001 || imWAddr !== '0 || imWData !== '0) begin
            n_fail++;
            $display("FAIL reset_values: rst/done/err/we/ready=%b%b%b%b%b addr=%h data=%h required 00001 0 0",
                     cpuRst_n, loadDone, loadErr, imWe, rxReady, imWAddr, imWData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({cpuRst_n, loadDone, rxReady} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_release: rst/done/ready=%b%b%b required 001", cpuRst_n, loadDone, rxReady);
        end
    endtask

    task automatic test_valid_frame();
        word_q = {32'h12345678, 32'hDEADBEEF};
        build_frame(1'b0);
        clear_writes();
        send_range(0, 0);
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr, rxReady} !== 4'b1100) begin
            n_fail++;
            $display("FAIL valid_done: rst/done/err/ready=%b%b%b%b required 1100", cpuRst_n, loadDone, loadErr, rxReady);
        end
        drop();
        check_writes("valid");
    endtask

    task automatic test_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({cpuRst_n, loadDone, rxReady} !== 3'b001) begin
            n_fail++;
            $display("FAIL reload: rst/done/ready=%b%b%b required 001", cpuRst_n, loadDone, rxReady);
        end
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_bad_csum();
        go_idle();
        word_q = {32'h12345678, 32'hDEADBEEF};
        build_frame(1'b1);
        clear_writes();
        send_range(0, 0);
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr, rxReady} !== 4'b0011) begin
            n_fail++;
            $display("FAIL bad_csum: rst/done/err/ready=%b%b%b%b required 0011", cpuRst_n, loadDone, loadErr, rxReady);
        end
        drop();
        word_q = {$urandom(), $urandom(), $urandom()};
        build_frame(1'b0);
        clear_writes();
        send_byte(byte_q[0]);
        n_checks++;
        if (loadErr !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear_on_start: loadErr=%b required 0", loadErr);
        end
        send_range(1, 0);
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr} !== 3'b110) begin
            n_fail++;
            $display("FAIL recover_done: rst/done/err=%b%b%b required 110", cpuRst_n, loadDone, loadErr);
        end
        drop();
        check_writes("recover");
    endtask

    task automatic test_back_to_back();
        int bad_gaps;
        go_idle();
        clear_writes();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        n_checks++;
        if ({loadErr, rxReady} !== 2'b11) begin
            n_fail++;
            $display("FAIL oversize: err/ready=%b%b required 11", loadErr, rxReady);
        end
        drop();
        n_checks++;
        if (wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL oversize_no_we: writes=%0d required 0", wr_addr_q.size());
        end
        word_q = {};
        for (int i = 0; i < (1 << AW); i++) word_q.push_back($urandom());
        build_frame(1'b0);
        clear_writes();
        send_range(0, 0);
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr} !== 3'b110) begin
            n_fail++;
            $display("FAIL full_done: rst/done/err=%b%b%b required 110", cpuRst_n, loadDone, loadErr);
        end
        drop();
        check_writes("full");
        bad_gaps = 0;
        for (int i = 1; i < wr_cyc_q.size(); i++)
            if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) bad_gaps++;
        n_checks++;
        if (bad_gaps != 0) begin
            n_fail++;
            $display("FAIL we_cadence: irregular_gaps=%0d required 0", bad_gaps);
        end
    endtask

    task automatic test_empty_frame();
        logic [7:0] b;
        go_idle();
        clear_writes();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        for (int i = 0; i < 3; i++) begin
            do b = 8'($urandom()); while (b == 8'hA5);
            send_byte(b);
        end
        n_checks++;
        if ({loadDone, rxReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL noise_ignored: done/ready=%b%b required 01", loadDone, rxReady);
        end
        word_q = {};
        build_frame(1'b0);
        send_range(0, 0);
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr} !== 3'b110 || wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL empty_frame: rst/done/err=%b%b%b writes=%0d required 110 0",
                     cpuRst_n, loadDone, loadErr, wr_addr_q.size());
        end
        drop();
    endtask

    task automatic test_timeout();
        go_idle();
        clear_writes();
        word_q = {32'h44332211};
        build_frame(1'b0);
        send_range(0, 0);
        // Rewind: only the first four bytes (A5 01 00 11) of that frame were meant to go.
        // Sending the whole frame above completed it; restart from DONE for the stall tests.
        drop();
        go_idle();
        for (int i = 0; i < 4; i++) send_byte(byte_q[i]);
        drop();
        repeat (TO - 1) @(posedge clk);
        #1;
        n_checks++;
        if (loadErr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: loadErr=%b required 0 after %0d idle cycles", loadErr, TO - 1);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({loadErr, rxReady, loadDone} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout: err/ready/done=%b%b%b required 110", loadErr, rxReady, loadDone);
        end
        clear_writes();
        for (int i = 0; i < 4; i++) send_byte(byte_q[i]);
        stall(TO - 1);
        send_range(4, 0);
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr} !== 3'b110) begin
            n_fail++;
            $display("FAIL stall_limit_ok: rst/done/err=%b%b%b required 110", cpuRst_n, loadDone, loadErr);
        end
        drop();
        check_writes("stall");
    endtask

    task automatic test_reset_mid_frame();
        go_idle();
        clear_writes();
        word_q = {$urandom()};
        build_frame(1'b0);
        for (int i = 0; i < 6; i++) send_byte(byte_q[i]);
        @(negedge clk);
        rxValid = 1'b0;
        rst_n   = 1'b0;
        #1;
        n_checks++;
        if ({cpuRst_n, loadDone, loadErr, imWe, rxReady} !== 5'b00001 || imWAddr !== '0 || imWData !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: rst/done/err/we/ready=%b%b%b%b%b addr=%h data=%h required 00001 0 0",
                     cpuRst_n, loadDone, loadErr, imWe, rxReady, imWAddr, imWData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wr_addr_q.size() != 0 || loadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_we: writes=%0d done=%b required 0 0", wr_addr_q.size(), loadDone);
        end
    endtask

    task automatic test_random_frames();
        bit bad;
        for (int f = 0; f < 8; f++) begin
            go_idle();
            clear_writes();
            word_q = {};
            for (int i = 0; i < $urandom_range(1, 12); i++) word_q.push_back($urandom());
            bad = ($urandom_range(0, 2) == 0);
            build_frame(bad);
            send_range(0, TO / 3);
            n_checks++;
            if (bad && {cpuRst_n, loadDone, loadErr} !== 3'b001) begin
                n_fail++;
                $display("FAIL rand%0d_bad: rst/done/err=%b%b%b required 001", f, cpuRst_n, loadDone, loadErr);
            end else if (!bad && {cpuRst_n, loadDone, loadErr} !== 3'b110) begin
                n_fail++;
                $display("FAIL rand%0d_good: rst/done/err=%b%b%b required 110", f, cpuRst_n, loadDone, loadErr);
            end
            drop();
            check_writes($sformatf("rand%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_reload();
        test_bad_csum();
        test_back_to_back();
        test_empty_frame();
        test_timeout();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
